// File: rtl/ifu_fq_pkg.sv
// rtl/ifu_fq_pkg.sv - shared opcodes, FSM state type and immediate extractors for ifu_fq
package ifu_fq_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // J-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_fq_fifo.sv
// rtl/ifu_fq_fifo.sv - circular fetch queue of {pc, instr, pred} entries with sync clear
module ifu_fq_fifo
  import ifu_fq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_wr_en,
  input  logic [XLEN-1:0]          i_wr_pc,
  input  logic [XLEN-1:0]          i_wr_instr,
  input  logic                     i_wr_pred,
  input  logic                     i_rd_en,
  output logic                     o_valid,
  output logic [XLEN-1:0]          o_pc,
  output logic [XLEN-1:0]          o_instr,
  output logic                     o_pred,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [XLEN-1:0] r_instr [DEPTH];
  logic            r_pred  [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  // Entry storage; contents are don't-care until counted as valid
  always_ff @(posedge clk) begin
    if (i_wr_en && !i_clr) begin
      r_pc[r_wptr]    <= i_wr_pc;
      r_instr[r_wptr] <= i_wr_instr;
      r_pred[r_wptr]  <= i_wr_pred;
    end
  end

  // Pointers and occupancy; clear wins over read/write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr_en) r_wptr <= r_wptr + AW'(1);
      if (i_rd_en) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_wr_en) - (AW+1)'(i_rd_en);
    end
  end

  // Illegal-use checks: read while empty, write while full
  always_ff @(posedge clk) begin
    if (rst && !i_clr) begin
      assert (!(i_rd_en && r_count == '0));
      assert (!(i_wr_en && !i_rd_en && r_count == (AW+1)'(DEPTH)));
    end
  end

  assign o_valid = (r_count != '0);
  assign o_pc    = o_valid ? r_pc[r_rptr]    : '0;
  assign o_instr = o_valid ? r_instr[r_rptr] : '0;
  assign o_pred  = o_valid ? r_pred[r_rptr]  : 1'b0;
  assign o_count = r_count;

endmodule

// File: rtl/ifu_fq.sv
// rtl/ifu_fq.sv - fetch unit: PC, imem handshake, static predecode, fetch queue (option IFU_BTFN_EN)
module ifu_fq
  import ifu_fq_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              FQ_DEPTH  = 4,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            flush_flag,
  input  logic [XLEN-1:0] flush_addr,
  output logic            fq_valid,
  input  logic            fq_ready,
  output logic [XLEN-1:0] fq_pc,
  output logic [XLEN-1:0] fq_instr,
  output logic            fq_pred_taken
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_req;

  logic            w_gnt;
  logic            w_enq;
  logic            w_deq;
  logic            w_pred;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_next_pc;
  logic [CW-1:0]   w_fifo_cnt;
  logic [CW-1:0]   w_fifo_cnt_nxt;
  logic [CW-1:0]   w_credit_nxt;

  assign w_gnt = r_req && imem_gnt;
  assign w_enq = (r_state == S_WAIT) && imem_rvalid && !flush_flag;
  assign w_deq = fq_valid && fq_ready && !flush_flag;

  // Static predecode of the returning instruction against the in-flight PC
  always_comb begin
    w_pred   = 1'b0;
    w_seq_pc = r_fetch_pc + XLEN'(4);
    w_target = w_seq_pc;
    case (imem_rdata[6:0])
      OPC_JAL: begin
        w_pred   = 1'b1;
        w_target = r_fetch_pc + XLEN'($signed(j_imm(imem_rdata[31:0])));
      end
`ifdef IFU_BTFN_EN
      OPC_BRANCH: begin
        if (imem_rdata[31]) begin
          w_pred   = 1'b1;
          w_target = r_fetch_pc + XLEN'($signed(b_imm(imem_rdata[31:0])));
        end
      end
`endif
      default: ;
    endcase
    w_next_pc = w_pred ? w_target : w_seq_pc;
  end

  // Next FSM state; a response always closes the transaction, a flush turns a live one into a drop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_gnt) w_state_nxt = flush_flag ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)     w_state_nxt = S_IDLE;
        else if (flush_flag) w_state_nxt = S_DROP;
      end
      S_DROP: if (imem_rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Credit = entries stored next cycle plus the slot reserved by a live request
  always_comb begin
    w_fifo_cnt_nxt = flush_flag ? '0 : (w_fifo_cnt + CW'(w_enq) - CW'(w_deq));
    w_credit_nxt   = w_fifo_cnt_nxt + CW'(w_state_nxt == S_WAIT);
  end

  // FSM, request register and fetch PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_fetch_pc <= BOOT_ADDR;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_IDLE) && (w_credit_nxt < CW'(FQ_DEPTH));
      if (flush_flag)  r_fetch_pc <= flush_addr;
      else if (w_enq)  r_fetch_pc <= w_next_pc;
    end
  end

  // A response is only legal while a request is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(imem_rvalid && r_state == S_IDLE));
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = {r_fetch_pc[XLEN-1:2], 2'b00};

  ifu_fq_fifo #(
    .XLEN  (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (flush_flag),
    .i_wr_en    (w_enq),
    .i_wr_pc    (r_fetch_pc),
    .i_wr_instr (imem_rdata),
    .i_wr_pred  (w_pred),
    .i_rd_en    (w_deq),
    .o_valid    (fq_valid),
    .o_pc       (fq_pc),
    .o_instr    (fq_instr),
    .o_pred     (fq_pred_taken),
    .o_count    (w_fifo_cnt)
  );

endmodule

// File: tb/tb_ifu_fq.sv
// tb/tb_ifu_fq.sv - directed self-checking bench for ifu_fq
module tb_ifu_fq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        flush_flag = 1'b0;
  logic [31:0] flush_addr = 32'h0;
  logic        fq_valid;
  logic        fq_ready = 1'b0;
  logic [31:0] fq_pc;
  logic [31:0] fq_instr;
  logic        fq_pred_taken;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic [31:0] nxt;
  } vec_t;

  vec_t vecs [7];

  ifu_fq #(.XLEN(32), .FQ_DEPTH(4), .BOOT_ADDR(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .flush_flag    (flush_flag),
    .flush_addr    (flush_addr),
    .fq_valid      (fq_valid),
    .fq_ready      (fq_ready),
    .fq_pc         (fq_pc),
    .fq_instr      (fq_instr),
    .fq_pred_taken (fq_pred_taken)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_wait", {31'd0, imem_req}, 32'd1);
  endtask

  // Grant the pending request, answer one cycle later; returns at the negedge after the response
  task automatic fetch_one(input logic [31:0] instr, output logic [31:0] addr);
    addr = 32'hxxxx_xxxx;
    wait_req();
    if (!imem_req) return;
    addr = imem_addr;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_rvalid = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    imem_gnt = 1'b0;
    flush_flag = 1'b1;
    flush_addr = pc;
    @(negedge clk);
    flush_flag = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int seen;

    vecs[0] = '{32'h0000_0008, 32'h0100_00EF, 1'b1, 32'h0000_0018};
    vecs[1] = '{32'h0000_0000, 32'hFF9F_F0EF, 1'b1, 32'hFFFF_FFF8};
`ifdef IFU_BTFN_EN
    vecs[2] = '{32'h0000_0020, 32'hFE00_0CE3, 1'b1, 32'h0000_0018};
`else
    vecs[2] = '{32'h0000_0020, 32'hFE00_0CE3, 1'b0, 32'h0000_0024};
`endif
    vecs[3] = '{32'h0000_0040, 32'h0000_0463, 1'b0, 32'h0000_0044};
    vecs[4] = '{32'h0000_0050, 32'h0000_80E7, 1'b0, 32'h0000_0054};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0100_00EF, 1'b1, 32'h0000_000C};
    vecs[6] = '{32'h0000_0010, NOP,           1'b0, 32'h0000_0014};

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, fq_valid}, 32'd0);
    check("rst_pc",    fq_pc, 32'h0);
    check("rst_instr", fq_instr, 32'h0);
    check("rst_pred",  {31'd0, fq_pred_taken}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    rst = 1'b1;
    fq_ready = 1'b1;

    // sequential NOP stream from BOOT_ADDR
    for (int i = 0; i < 4; i++) begin
      fetch_one(NOP, a);
      check("seq_addr", a, 32'(i * 4));
      check("seq_valid", {31'd0, fq_valid}, 32'd1);
      check("seq_pc", fq_pc, 32'(i * 4));
      check("seq_pred", {31'd0, fq_pred_taken}, 32'd0);
    end

    // predecode table
    for (int i = 0; i < 7; i++) begin
      set_pc(vecs[i].pc);
      fetch_one(vecs[i].instr, a);
      check("vec_addr", a, vecs[i].pc);
      check("vec_valid", {31'd0, fq_valid}, 32'd1);
      check("vec_pc", fq_pc, vecs[i].pc);
      check("vec_instr", fq_instr, vecs[i].instr);
      check("vec_pred", {31'd0, fq_pred_taken}, {31'd0, vecs[i].pred});
      wait_req();
      check("vec_next", imem_addr, vecs[i].nxt);
    end

    // back-pressure: exactly FQ_DEPTH fetches, then one slot freed -> one more
    fq_ready = 1'b0;
    set_pc(32'h0000_0200);
    for (int i = 0; i < 4; i++) begin
      fetch_one(NOP, a);
      check("bp_addr", a, 32'h200 + 32'(i * 4));
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req) seen++;
      @(negedge clk);
    end
    check("bp_full_noreq", 32'(seen), 32'd0);
    check("bp_head", fq_pc, 32'h0000_0200);
    fq_ready = 1'b1;
    @(negedge clk);
    fq_ready = 1'b0;
    check("bp_one_req", {31'd0, imem_req}, 32'd1);
    check("bp_one_addr", imem_addr, 32'h0000_0210);
    check("bp_head2", fq_pc, 32'h0000_0204);
    fetch_one(NOP, a);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req) seen++;
      @(negedge clk);
    end
    check("bp_refull_noreq", 32'(seen), 32'd0);
    fq_ready = 1'b1;

    // flush while waiting: response dropped, refetch at flush target
    set_pc(32'h0000_0300);
    wait_req();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    flush_flag = 1'b1;
    flush_addr = 32'h0000_0100;
    @(negedge clk);
    flush_flag = 1'b0;
    check("drop_req", {31'd0, imem_req}, 32'd0);
    check("drop_valid", {31'd0, fq_valid}, 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0100_00EF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("drop_valid2", {31'd0, fq_valid}, 32'd0);
    check("drop_req2", {31'd0, imem_req}, 32'd1);
    check("drop_addr", imem_addr, 32'h0000_0100);
    fetch_one(NOP, a);
    check("drop_refetch_pc", fq_pc, 32'h0000_0100);

    // reset during WAIT, stale response while in reset
    set_pc(32'h0000_0400);
    wait_req();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, fq_valid}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata = NOP;
    @(negedge clk);
    imem_rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_valid", {31'd0, fq_valid}, 32'd0);
    fetch_one(NOP, a);
    check("post_rst_pc", fq_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
